// File: rtl/z16_pkg.sv
// Shared Z16 front-end types and constants: fetch FSM states, the buffered
// {pc, instr} payload and the PC increment helper.
package z16_pkg;

    localparam int unsigned Z16_XLEN        = 16;
    localparam int unsigned Z16_INSTR_BYTES = 2;

    localparam logic [Z16_XLEN-1:0] Z16_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [Z16_XLEN-1:0] pc;
        logic [Z16_XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential PC; wraps FFFE -> 0000 through the natural 16-bit overflow
    function automatic logic [Z16_XLEN-1:0] pc_incr(input logic [Z16_XLEN-1:0] pc);
        return pc + Z16_XLEN'(Z16_INSTR_BYTES);
    endfunction

endpackage

// File: rtl/z16_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush and a
// registered head, so the decoder sees flop outputs only.
module z16_fetch_fifo
    import z16_pkg::*;
#(
    parameter  int unsigned P_DEPTH = 2,
    localparam int unsigned CNT_W   = $clog2(P_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output logic               head_valid,
    output fetch_entry_t       head
);

    localparam int unsigned AW = $clog2(P_DEPTH);

    fetch_entry_t     mem [P_DEPTH];
    logic [AW-1:0]    rd_ptr, rd_ptr_n;
    logic [AW-1:0]    wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0] count_n;
    logic             head_valid_n;
    fetch_entry_t     head_n;
    logic             do_push;
    logic             do_pop;

    // Next-state for pointers, occupancy and the registered head copy
    always_comb begin
        do_pop       = pop && !flush && (count != '0);
        do_push      = push && !flush && ((count != CNT_W'(P_DEPTH)) || do_pop);
        rd_ptr_n     = rd_ptr;
        wr_ptr_n     = wr_ptr;
        count_n      = count;
        head_valid_n = head_valid;
        head_n       = head;
        if (flush) begin
            rd_ptr_n     = '0;
            wr_ptr_n     = '0;
            count_n      = '0;
            head_valid_n = 1'b0;
            head_n       = '0;
        end else begin
            if (do_push) begin
                wr_ptr_n = wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_n = rd_ptr + AW'(1);
            end
            count_n = count + CNT_W'(do_push) - CNT_W'(do_pop);
            if (do_pop) begin
                // Last entry leaving: the head is either the bypassed push or empty
                if (count == CNT_W'(1)) begin
                    head_valid_n = do_push;
                    head_n       = do_push ? push_data : '0;
                end else begin
                    head_valid_n = 1'b1;
                    head_n       = mem[rd_ptr + AW'(1)];
                end
            end else if ((count == '0) && do_push) begin
                head_valid_n = 1'b1;
                head_n       = push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
            for (int unsigned i = 0; i < P_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            count      <= count_n;
            head_valid <= head_valid_n;
            head       <= head_n;
            if (do_push) begin
                mem[wr_ptr] <= push_data;
            end
        end
    end

endmodule

// File: rtl/z16_fetch.sv
// Z16 instruction fetch: owns the PC, keeps one imem read in flight, buffers
// responses for decode and handles redirects. Optional perf counters: Z16_FETCH_PERF_CNT_EN.
module z16_fetch
    import z16_pkg::*;
#(
    parameter logic [Z16_XLEN-1:0] P_RESET_PC  = Z16_RESET_PC,
    parameter int unsigned         P_BUF_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_imem_req,
    output logic [Z16_XLEN-1:0] o_imem_addr,
    input  logic                i_imem_gnt,
    input  logic                i_imem_rvalid,
    input  logic [Z16_XLEN-1:0] i_imem_rdata,
    output logic                o_instr_valid,
    output logic [Z16_XLEN-1:0] o_instr,
    output logic [Z16_XLEN-1:0] o_instr_pc,
    input  logic                i_instr_ready,
    input  logic                i_redirect,
    input  logic [Z16_XLEN-1:0] i_redirect_pc
`ifdef Z16_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         o_fetch_cnt,
    output logic [15:0]         o_drop_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(P_BUF_DEPTH + 1);

    fetch_state_t        state, state_n;
    logic [Z16_XLEN-1:0] pc, pc_n;
    logic [Z16_XLEN-1:0] req_pc, req_pc_n;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    count_after_push;
    logic                push;
    logic                pop;
    logic                req_c;
    logic                hs;
    logic                head_valid;
    fetch_entry_t        push_data;
    fetch_entry_t        head;

    assign pop              = head_valid && i_instr_ready && !i_redirect;
    assign push             = (state == S_WAIT) && i_imem_rvalid && !i_redirect;
    assign push_data        = '{pc: req_pc, instr: i_imem_rdata};
    assign count_after_push = fifo_count + CNT_W'(1) - CNT_W'(pop);

    // Request only when the response is guaranteed a FIFO slot
    always_comb begin
        req_c = 1'b0;
        if (!i_rst && !i_redirect) begin
            case (state)
                S_REQ:   req_c = (fifo_count < CNT_W'(P_BUF_DEPTH));
                S_WAIT:  req_c = i_imem_rvalid && (count_after_push < CNT_W'(P_BUF_DEPTH));
                default: req_c = 1'b0;
            endcase
        end
    end

    assign hs          = req_c && i_imem_gnt;
    assign o_imem_req  = req_c;
    assign o_imem_addr = req_c ? pc : '0;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        req_pc_n = req_pc;
        if (i_redirect) begin
            pc_n = i_redirect_pc & 16'hFFFE;
            // A response arriving in the redirect cycle retires the old request
            case (state)
                S_WAIT:  state_n = i_imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  state_n = i_imem_rvalid ? S_REQ : S_DROP;
                default: state_n = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (hs) begin
                        req_pc_n = pc;
                        pc_n     = pc_incr(pc);
                        state_n  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (hs) begin
                            req_pc_n = pc;
                            pc_n     = pc_incr(pc);
                            state_n  = S_WAIT;
                        end else begin
                            state_n = S_REQ;
                        end
                    end
                end
                S_DROP: begin
                    if (i_imem_rvalid) begin
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_REQ;
            pc     <= P_RESET_PC;
            req_pc <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            req_pc <= req_pc_n;
        end
    end

    z16_fetch_fifo #(
        .P_DEPTH (P_BUF_DEPTH)
    ) u_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (i_redirect),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign o_instr_valid = head_valid;
    assign o_instr       = head.instr;
    assign o_instr_pc    = head.pc;

`ifdef Z16_FETCH_PERF_CNT_EN
    logic drop_evt;

    assign drop_evt = (state == S_DROP) && i_imem_rvalid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_fetch_cnt <= '0;
            o_drop_cnt  <= '0;
        end else begin
            o_fetch_cnt <= o_fetch_cnt + 32'(pop);
            o_drop_cnt  <= o_drop_cnt + 16'(drop_evt);
        end
    end
`endif

endmodule

// File: tb/tb_z16_fetch.sv
// Scoreboard bench for z16_fetch: an imem model with programmable grant delay,
// read latency and grant budget, plus a decoder-side monitor.
module tb_z16_fetch;
    import z16_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [15:0] i_imem_rdata = 16'h0000;
    logic        o_instr_valid;
    logic [15:0] o_instr;
    logic [15:0] o_instr_pc;
    logic        i_instr_ready = 1'b1;
    logic        i_redirect = 1'b0;
    logic [15:0] i_redirect_pc = 16'h0000;
`ifdef Z16_FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_cnt;
    logic [15:0] o_drop_cnt;
`endif

    z16_fetch #(
        .P_RESET_PC  (16'h0000),
        .P_BUF_DEPTH (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_instr_ready (i_instr_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
`ifdef Z16_FETCH_PERF_CNT_EN
        ,
        .o_fetch_cnt   (o_fetch_cnt),
        .o_drop_cnt    (o_drop_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    logic [15:0] exp_addr[$];

    // imem model state
    int          gnt_delay = 0;
    int          rv_lat = 1;
    int          budget = 0;
    logic        outst = 1'b0;
    logic [15:0] outst_addr = 16'h0000;
    int          rv_cnt = 0;
    logic        hs_pend = 1'b0;
    logic [15:0] hs_addr = 16'h0000;
    int          hs_lat = 1;
    int          req_wait = 0;
    int          hs_count = 0;
    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    int          first_hs_cyc = -1;
    int          last_hs_cyc = -1;
    int          first_valid_cyc = -1;
    logic [31:0] mon_e;
    int          h0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input int n, input logic with_data);
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            p = a + 16'(2 * i);
            exp_addr.push_back(p);
            if (with_data) exp_q.push_back({p, mem_word(p)});
        end
    endtask

    task automatic redirect_to(input logic [15:0] a);
        @(negedge i_clk);
        i_redirect    = 1'b1;
        i_redirect_pc = a;
        @(negedge i_clk);
        i_redirect    = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || budget != 0 || outst || hs_pend) && n < max_cyc) begin
            @(negedge i_clk);
            n++;
        end
        check(name, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic wait_grant(input string name, input int base);
        int n;
        n = 0;
        while (hs_count == base && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check(name, 32'(hs_count - base), 32'd1);
    endtask

    // imem: drives rvalid at negedge, then grants against the settled request
    initial forever begin
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rdata  = 16'h0000;
        if (i_rst) begin
            outst     = 1'b0;
            hs_pend   = 1'b0;
            req_wait  = 0;
            prev_wait = 1'b0;
        end else begin
            if (hs_pend) begin
                outst      = 1'b1;
                outst_addr = hs_addr;
                rv_cnt     = hs_lat;
                hs_pend    = 1'b0;
            end
            if (outst) begin
                if (rv_cnt <= 1) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = mem_word(outst_addr);
                    outst         = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            #1;
            if (o_imem_req) begin
                check("one_outstanding", 32'(outst), 32'd0);
                if (prev_wait) check("addr_stable", 32'(o_imem_addr), 32'(prev_addr));
                if (budget > 0 && req_wait >= gnt_delay) begin
                    i_imem_gnt = 1'b1;
                    budget--;
                    hs_pend  = 1'b1;
                    hs_addr  = o_imem_addr;
                    hs_lat   = rv_lat;
                    hs_count++;
                    if (first_hs_cyc < 0) first_hs_cyc = cyc;
                    last_hs_cyc = cyc;
                    if (exp_addr.size() > 0) check("req_addr", 32'(o_imem_addr), 32'(exp_addr.pop_front()));
                    prev_wait = 1'b0;
                    req_wait  = 0;
                end else begin
                    if (budget > 0) req_wait++;
                    prev_wait = 1'b1;
                    prev_addr = o_imem_addr;
                end
            end else begin
                check("addr_idle_zero", 32'(o_imem_addr), 32'd0);
                prev_wait = 1'b0;
                req_wait  = 0;
            end
        end
    end

    // Decoder-side monitor: every accepted instruction must match the queue head
    initial forever begin
        @(negedge i_clk);
        #2;
        if (!i_rst && o_instr_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (i_instr_ready && !i_redirect) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_instr: got pc %h instr %h expected none", o_instr_pc, o_instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr_pc", 32'(o_instr_pc), 32'(mon_e[31:16]));
                    check("instr", 32'(o_instr), 32'(mon_e[15:0]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(negedge i_clk);
        #2;
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_valid", 32'(o_instr_valid), 32'd0);
        check("rst_instr", 32'(o_instr), 32'd0);
        check("rst_pc", 32'(o_instr_pc), 32'd0);

        // Streaming with 1-cycle memory
        push_exp(16'h0000, 8, 1'b1);
        budget = 8;
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        wait_drain("p1_drain", 200);
        check("p1_first_latency", 32'(first_valid_cyc - first_hs_cyc), 32'd2);
        check("p1_back_to_back", 32'(last_hs_cyc - first_hs_cyc), 32'd7);

        // Backpressure: only two requests while the decoder stalls
        redirect_to(16'h0100);
        push_exp(16'h0100, 5, 1'b1);
        i_instr_ready = 1'b0;
        h0 = hs_count;
        budget = 5;
        repeat (10) @(negedge i_clk);
        #2;
        check("p2_buffered", 32'(hs_count - h0), 32'd2);
        check("p2_req_low", 32'(o_imem_req), 32'd0);
        check("p2_head_valid", 32'(o_instr_valid), 32'd1);
        check("p2_head_pc", 32'(o_instr_pc), 32'h0100);
        check("p2_head_instr", 32'(o_instr), 32'(mem_word(16'h0100)));
        @(negedge i_clk);
        i_instr_ready = 1'b1;
        wait_drain("p2_drain", 200);

        // Redirect with a buffered entry and a request in flight
        i_instr_ready = 1'b0;
        push_exp(16'h010A, 1, 1'b0);
        rv_lat = 1;
        budget = 1;
        for (int i = 0; i < 50 && !o_instr_valid; i++) @(negedge i_clk);
        check("p3_one_buffered", 32'(o_instr_valid), 32'd1);
        rv_lat = 4;
        h0 = hs_count;
        push_exp(16'h010C, 1, 1'b0);
        budget = 1;
        wait_grant("p3_granted", h0);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0041;
        push_exp(16'h0040, 2, 1'b1);
        budget = 2;
        @(negedge i_clk);
        i_redirect = 1'b0;
        check("p3_flushed", 32'(o_instr_valid), 32'd0);
        i_instr_ready = 1'b1;
        wait_drain("p3_drain", 200);

        // Slow grant, long read latency
        gnt_delay = 3;
        rv_lat = 4;
        push_exp(16'h0044, 3, 1'b1);
        budget = 3;
        wait_drain("p4_drain", 300);

        // PC wrap
        gnt_delay = 0;
        rv_lat = 1;
        redirect_to(16'hFFFC);
        push_exp(16'hFFFC, 3, 1'b1);
        budget = 3;
        wait_drain("p5_drain", 200);

        // Asynchronous reset in the middle of a burst
        redirect_to(16'h0200);
        for (int i = 0; i < 20; i++) exp_q.push_back({16'h0200 + 16'(2 * i), mem_word(16'h0200 + 16'(2 * i))});
        budget = 100;
        repeat (6) @(negedge i_clk);
        #3 i_rst = 1'b1;
        #1;
        check("arst_req", 32'(o_imem_req), 32'd0);
        check("arst_addr", 32'(o_imem_addr), 32'd0);
        check("arst_valid", 32'(o_instr_valid), 32'd0);
        check("arst_instr", 32'(o_instr), 32'd0);
        check("arst_pc", 32'(o_instr_pc), 32'd0);
`ifdef Z16_FETCH_PERF_CNT_EN
        check("arst_fetch_cnt", o_fetch_cnt, 32'd0);
        check("arst_drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
        repeat (2) @(negedge i_clk);
        exp_q.delete();
        exp_addr.delete();
        budget = 0;
        @(posedge i_clk);
        #2 i_rst = 1'b0;

        // Restart from the reset PC, then one dropped response
        push_exp(16'h0000, 5, 1'b1);
        budget = 5;
        wait_drain("p7_drain", 200);
        rv_lat = 4;
        h0 = hs_count;
        push_exp(16'h000A, 1, 1'b0);
        budget = 1;
        wait_grant("p7_granted", h0);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0300;
        @(negedge i_clk);
        i_redirect = 1'b0;
        repeat (8) @(negedge i_clk);
        #2;
        check("p7_req_after_drop", 32'(o_imem_addr), 32'h0300);
        check("p7_no_stale", 32'(o_instr_valid), 32'd0);
`ifdef Z16_FETCH_PERF_CNT_EN
        check("p7_fetch_cnt", o_fetch_cnt, 32'd5);
        check("p7_drop_cnt", 32'(o_drop_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/z16_fetch.md
Name: z16_fetch

Overview:
- Z16 instruction-fetch stage, directly upstream of the decoder.
- Owns the PC and issues word reads to instruction memory, one outstanding request at most.
- Buffers returned 16-bit instructions in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump) from later stages, flushes buffered and in-flight instructions, and restarts fetch at the new PC.

Parameters:
- P_RESET_PC, 16'h0000, PC loaded on reset; bit 0 must be 0.
- P_BUF_DEPTH, 2, instruction FIFO depth; legal values 2 or 4.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- o_imem_req  output  1  read request valid.
- o_imem_addr  output  16  byte address of requested instruction.
- i_imem_gnt  input  1  request accepted this cycle (req && gnt = handshake).
- i_imem_rvalid  input  1  read data valid; ≥1 cycle after handshake, in order.
- i_imem_rdata  input  16  instruction word.
- o_instr_valid  output  1  FIFO head valid toward decoder.
- o_instr  output  16  FIFO head instruction (drives decoder i_instr).
- o_instr_pc  output  16  PC of FIFO head.
- i_instr_ready  input  1  decoder consumes head when valid && ready.
- i_redirect  input  1  flush and restart fetch.
- i_redirect_pc  input  16  new PC; bit 0 ignored, treated as 0.

Behaviour:
- Reset (async assert, sync release): PC=P_RESET_PC, FIFO empty, state S_REQ. o_imem_req=0, o_instr_valid=0, o_instr=0, o_instr_pc=0 while i_rst high.
- States:
  - S_REQ: o_imem_req=1 iff (fifo_count < P_BUF_DEPTH). On gnt: latch req_pc=PC, PC<=PC+2 (16-bit wrap, FFFE→0000), go S_WAIT.
  - S_WAIT: o_imem_req=0. On rvalid: push {rdata, req_pc} into FIFO, go S_REQ.
  - S_DROP: o_imem_req=0. On rvalid: discard data, go S_REQ.
- o_imem_addr=PC whenever o_imem_req=1; 0 otherwise.
- Slot reservation: request is issued only if a FIFO slot is guaranteed for its response, so a push never overflows.
- Push and pop in the same cycle are legal; count is unchanged.
- Latency: gnt at cycle N, rvalid at N+1 → o_instr_valid at N+2 if FIFO was empty.
- Sustained throughput: 1 instr/cycle needs gnt in the same cycle as rvalid, so S_WAIT with rvalid and space left may re-request in the same cycle. Adopted rule: in S_WAIT, when rvalid and a slot is free after the push, assert req combinationally. On gnt, stay in S_WAIT with the new req_pc.
- o_instr/o_instr_pc hold stable while o_instr_valid && !i_instr_ready. Values are don't-care when not valid but driven to 0.
- Redirect (highest priority, same-cycle effect on next edge):
  - FIFO cleared; PC<=i_redirect_pc & 16'hFFFE.
  - A push or pop in the same cycle is ignored.
  - No request is asserted in the redirect cycle.
  - If a response is outstanding (S_WAIT, or a gnt this cycle) → S_DROP; else → S_REQ.
  - rvalid in the redirect cycle for the old request counts as delivered and is dropped; go S_REQ unless a new gnt occurred (it cannot, since req is masked).
  - Redirect while in S_DROP: stay S_DROP, update PC.
- rvalid in S_REQ (no outstanding request) is a protocol error: ignored.

Optional Feature:
- Macro: Z16_FETCH_PERF_CNT_EN.
- Defined: adds o_fetch_cnt (output, 32) counting instructions accepted by the decoder (valid && ready, not during redirect), and o_drop_cnt (output, 16) counting responses discarded in S_DROP. Both are reset to 0 and wrap on overflow.
- Undefined: neither port nor counter exists; all other behaviour identical.

Decomposition:
- Shared package z16_pkg holds:
  - state enum {S_REQ, S_WAIT, S_DROP};
  - Z16_XLEN=16, Z16_INSTR_BYTES=2;
  - P_RESET_PC default constant.
- One sub-module: z16_fetch_fifo, a parameterised synchronous FIFO of {pc, instr} with push, pop, flush, count, and a registered head.

Test Plan:
- Reset release, memory with 1-cycle rvalid, gnt=1, ready=1 → addresses 0000,0002,0004… on consecutive cycles; first o_instr_valid 2 cycles after first gnt; o_instr_pc matches.
- Decoder ready=0 for 10 cycles → exactly P_BUF_DEPTH instructions buffered; o_imem_req=0; head stable. Release ready → in-order drain, no loss or duplicate.
- Redirect to 0x0041 while one request is outstanding → next req addr 0x0040; stale rdata dropped, never valid at output; FIFO empty the cycle after redirect.
- gnt delayed 3 cycles, rvalid latency 4 → addr held stable during req; one outstanding max; correct order.
- Fetch from PC=FFFE → next request addr 0000.
- Async i_rst asserted mid-burst (between edges) → outputs zero immediately; restart from P_RESET_PC. With Z16_FETCH_PERF_CNT_EN, 5 accepted + 1 dropped → o_fetch_cnt=5, o_drop_cnt=1.
